// File: rtl/flow_stream_controller.sv
// Frame sequencer and output stage behind the flow solver: launches frames, tags vectors with
// raster position / last-of-frame, zeroes the window border and buffers into a FWFT FIFO.
module flow_stream_controller #(
    parameter int IMAGE_WIDTH     = 320,
    parameter int IMAGE_HEIGHT    = 240,
    parameter int FLOW_WIDTH      = 16,
    parameter int WINDOW_SIZE     = 5,
    parameter int FIFO_DEPTH      = 16,
    parameter int FRAME_CNT_WIDTH = 16,
    localparam int XW = $clog2(IMAGE_WIDTH),
    localparam int YW = $clog2(IMAGE_HEIGHT)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       abort,
    input  logic                       continuous,
    input  logic [FRAME_CNT_WIDTH-1:0] num_frames,
    output logic                       frame_start,
    output logic                       busy,
    output logic                       done,
    output logic [FRAME_CNT_WIDTH-1:0] frame_count,
    output logic                       overflow,
    input  logic [FLOW_WIDTH-1:0]      in_flow_u,
    input  logic [FLOW_WIDTH-1:0]      in_flow_v,
    input  logic                       in_flow_valid,
    output logic [FLOW_WIDTH-1:0]      out_u,
    output logic [FLOW_WIDTH-1:0]      out_v,
    output logic [XW-1:0]              out_x,
    output logic [YW-1:0]              out_y,
    output logic                       out_border,
    output logic                       out_last,
    output logic                       out_valid,
    input  logic                       out_ready
);

    localparam int R  = WINDOW_SIZE / 2;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = 2 * FLOW_WIDTH + XW + YW + 2;

    localparam logic [XW-1:0] X_LO  = XW'(R);
    localparam logic [XW-1:0] X_HI  = XW'(IMAGE_WIDTH - R);
    localparam logic [XW-1:0] X_MAX = XW'(IMAGE_WIDTH - 1);
    localparam logic [YW-1:0] Y_LO  = YW'(R);
    localparam logic [YW-1:0] Y_HI  = YW'(IMAGE_HEIGHT - R);
    localparam logic [YW-1:0] Y_MAX = YW'(IMAGE_HEIGHT - 1);
    localparam logic [AW:0]   DEPTH_V = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                     state;
    logic [XW-1:0]              x;
    logic [YW-1:0]              y;
    logic [FRAME_CNT_WIDTH-1:0] frames_target;
    logic [FRAME_CNT_WIDTH:0]   completed;

    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic          push_req;
    logic          push;
    logic          pop;
    logic          full;
    logic          at_border;
    logic          at_last;
    logic [EW-1:0] wr_entry;
    logic [EW-1:0] rd_entry;

    assign full      = (count == DEPTH_V);
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign push_req  = (state == S_RUN) && in_flow_valid && !abort;
    // A full FIFO still takes a vector when the consumer frees a slot in the same cycle.
    assign push      = push_req && (!full || pop);

    assign at_border = (x < X_LO) || (x >= X_HI) || (y < Y_LO) || (y >= Y_HI);
    assign at_last   = (x == X_MAX) && (y == Y_MAX);
    assign completed = {1'b0, frame_count} + 1'b1;

    assign wr_entry = {at_border ? '0 : in_flow_u,
                       at_border ? '0 : in_flow_v,
                       x, y, at_border, at_last};

    assign rd_entry = out_valid ? mem[rd_ptr] : '0;
    assign {out_u, out_v, out_x, out_y, out_border, out_last} = rd_entry;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || abort) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Strobe outputs are registered alongside the state they belong to.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            x             <= '0;
            y             <= '0;
            frames_target <= '0;
            frame_count   <= '0;
            overflow      <= 1'b0;
            frame_start   <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            done        <= 1'b0;
            if (push_req && !push) begin
                overflow <= 1'b1;
            end
            if (abort) begin
                state <= S_IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            state         <= S_LAUNCH;
                            busy          <= 1'b1;
                            frame_start   <= 1'b1;
                            frame_count   <= '0;
                            overflow      <= 1'b0;
                            frames_target <= (num_frames == '0) ? FRAME_CNT_WIDTH'(1) : num_frames;
                        end
                    end
                    S_LAUNCH: begin
                        state <= S_RUN;
                        x     <= '0;
                        y     <= '0;
                    end
                    S_RUN: begin
                        // Position advances even for dropped vectors so the frame ends on count.
                        if (push_req) begin
                            if (at_last) begin
                                state <= S_DRAIN;
                            end else if (x == X_MAX) begin
                                x <= '0;
                                y <= y + 1'b1;
                            end else begin
                                x <= x + 1'b1;
                            end
                        end
                    end
                    S_DRAIN: begin
                        if (count == '0) begin
                            if (frame_count != '1) begin
                                frame_count <= frame_count + 1'b1;
                            end
                            if (continuous || (completed < {1'b0, frames_target})) begin
                                state       <= S_LAUNCH;
                                frame_start <= 1'b1;
                            end else begin
                                state <= S_DONE;
                                done  <= 1'b1;
                            end
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_flow_stream_controller.sv
// Randomized bench for flow_stream_controller: a queue-based model of the output stream plus
// run-level expectations (frame pulses, done, frame_count) derived from the sequencing rules.
module tb_flow_stream_controller;

    localparam int W     = 8;
    localparam int H     = 4;
    localparam int WS    = 3;
    localparam int R     = WS / 2;
    localparam int DEPTH = 4;
    localparam int FW    = 16;
    localparam int FCW   = 16;
    localparam int XW    = $clog2(W);
    localparam int YW    = $clog2(H);
    localparam int EW    = 2 * FW + XW + YW + 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic           abort;
    logic           continuous;
    logic [FCW-1:0] num_frames;
    logic           frame_start;
    logic           busy;
    logic           done;
    logic [FCW-1:0] frame_count;
    logic           overflow;
    logic [FW-1:0]  in_flow_u;
    logic [FW-1:0]  in_flow_v;
    logic           in_flow_valid;
    logic [FW-1:0]  out_u;
    logic [FW-1:0]  out_v;
    logic [XW-1:0]  out_x;
    logic [YW-1:0]  out_y;
    logic           out_border;
    logic           out_last;
    logic           out_valid;
    logic           out_ready;

    logic [EW-1:0] q[$];
    logic [EW-1:0] drv_entry;
    bit            drv_real;
    bit            drv_start_real;
    bit            m_overflow;
    int            m_drops;
    bit            active;
    int            errors = 0;
    int            checks = 0;

    flow_stream_controller #(
        .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .FLOW_WIDTH(FW),
        .WINDOW_SIZE(WS), .FIFO_DEPTH(DEPTH), .FRAME_CNT_WIDTH(FCW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .continuous(continuous), .num_frames(num_frames),
        .frame_start(frame_start), .busy(busy), .done(done),
        .frame_count(frame_count), .overflow(overflow),
        .in_flow_u(in_flow_u), .in_flow_v(in_flow_v), .in_flow_valid(in_flow_valid),
        .out_u(out_u), .out_v(out_v), .out_x(out_x), .out_y(out_y),
        .out_border(out_border), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] allOutputs();
        return {frame_start, busy, done, frame_count, overflow, out_u, out_v,
                out_x, out_y, out_border, out_last, out_valid};
    endfunction

    // One clock: the model consumes what was driven, then DUT outputs are compared at negedge.
    task automatic applyStimulus();
        bit pop_m;
        pop_m = (q.size() != 0) && out_ready;
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            m_overflow = 0;
        end else if (abort) begin
            q.delete();
        end else begin
            if (drv_start_real) m_overflow = 0;
            if (pop_m) void'(q.pop_front());
            if (drv_real) begin
                if (q.size() < DEPTH) q.push_back(drv_entry);
                else begin
                    m_overflow = 1;
                    m_drops++;
                end
            end
        end
        @(negedge clk);
        checkOutput("out_valid", out_valid, q.size() != 0);
        if (q.size() != 0)
            checkOutput("out_vec", {out_u, out_v, out_x, out_y, out_border, out_last}, q[0]);
        checkOutput("overflow", overflow, m_overflow);
    endtask

    task automatic idleInputs();
        start          = 0;
        abort          = 0;
        in_flow_valid  = 0;
        in_flow_u      = '0;
        in_flow_v      = '0;
        drv_real       = 0;
        drv_start_real = 0;
    endtask

    // kill_mode: 0 none, 1 abort, 2 reset; hold_n < 0 selects random valid/ready.
    task automatic runFrames(input int nf, input int cont_until, input int kill_mode,
                             input int kill_frame, input int hold_n, input bit fixed_uv);
        int nf_eff, exp_frames, starts_seen, sent, dut_pops, cycles, kdone, px, py;
        bit finished, fs, bd, lst;
        logic [FW-1:0] u, v;
        nf_eff     = (nf == 0) ? 1 : nf;
        exp_frames = (cont_until > nf_eff) ? cont_until : nf_eff;
        m_drops    = 0;
        starts_seen = 0; sent = 0; dut_pops = 0; cycles = 0; finished = 0; kdone = 0;
        idleInputs();
        num_frames     = FCW'(nf);
        continuous     = (cont_until > 0);
        start          = 1;
        drv_start_real = 1;
        out_ready      = (hold_n > 0) ? 1'b0 : 1'b1;
        applyStimulus();
        idleInputs();
        active = 0;
        while (!finished && cycles < 4000) begin
            cycles++;
            if (done) begin
                finished = 1;
            end else begin
                checkOutput("busy_run", busy, 1);
                fs = frame_start;
                if (kill_mode != 0 && active && starts_seen == kill_frame && sent == 10) begin
                    finished = 1;
                    active   = 0;
                    if (kill_mode == 1) begin
                        abort = 1; start = 1; in_flow_valid = 1; drv_real = 0;
                        applyStimulus();
                        checkOutput("abort_busy", busy, 0);
                        checkOutput("abort_flush", out_valid, 0);
                        checkOutput("abort_fcount", frame_count, kill_frame - 1);
                    end else begin
                        rst_n = 0; drv_real = 0; in_flow_valid = 1;
                        applyStimulus();
                        checkOutput("reset_outputs", allOutputs(), 0);
                        rst_n = 1;
                    end
                    idleInputs();
                    for (int i = 0; i < 2 * W * H; i++) begin
                        in_flow_valid = 1'($urandom_range(0, 1));
                        out_ready     = 1'($urandom_range(0, 1));
                        applyStimulus();
                        if (done) kdone++;
                    end
                    checkOutput("kill_no_done", kdone, 0);
                    checkOutput("kill_idle", busy, 0);
                end else begin
                    drv_real = 0; in_flow_valid = 0;
                    if (hold_n >= 0) begin
                        start     = 0;
                        out_ready = !(starts_seen <= 1 && sent < hold_n);
                        if (hold_n > 0 && active && starts_seen == 1 && sent == hold_n) begin
                            checkOutput("hold_overflow", overflow, hold_n > DEPTH);
                            checkOutput("hold_head_x", out_x, 0);
                        end
                    end else begin
                        start      = ($urandom_range(0, 15) == 0);
                        out_ready  = ($urandom_range(0, 7) != 0);
                        num_frames = FCW'($urandom);
                    end
                    if (active && (hold_n >= 0 || $urandom_range(0, 1) == 1)) begin
                        u  = fixed_uv ? FW'(5) : FW'($urandom);
                        v  = fixed_uv ? FW'(5) : FW'($urandom);
                        px = sent % W;
                        py = sent / W;
                        bd = (px < R) || (px >= W - R) || (py < R) || (py >= H - R);
                        lst = (sent == W * H - 1);
                        drv_entry = {bd ? FW'(0) : u, bd ? FW'(0) : v, XW'(px), YW'(py), bd, lst};
                        in_flow_u = u; in_flow_v = v; in_flow_valid = 1; drv_real = 1;
                        sent++;
                        if (sent == W * H) active = 0;
                    end else if (!active && hold_n < 0 && $urandom_range(0, 3) == 0) begin
                        in_flow_u = FW'($urandom); in_flow_v = FW'($urandom); in_flow_valid = 1;
                    end
                    if (fs) begin
                        starts_seen++;
                        if (starts_seen == 1) checkOutput("fcount_cleared", frame_count, 0);
                        if (starts_seen == cont_until) continuous = 0;
                        active = 1;
                        sent   = 0;
                    end
                    if (out_valid && out_ready) dut_pops++;
                    applyStimulus();
                end
            end
        end
        if (!finished) checkOutput("run_timeout", 1, 0);
        if (kill_mode == 0) begin
            checkOutput("frame_starts", starts_seen, exp_frames);
            checkOutput("frame_count", frame_count, exp_frames);
            checkOutput("outputs_seen", dut_pops, exp_frames * W * H - m_drops);
            idleInputs();
            applyStimulus();
            checkOutput("done_pulse", done, 0);
            checkOutput("busy_after", busy, 0);
        end
        idleInputs();
        continuous = 0;
    endtask

    initial begin
        rst_n      = 0;
        continuous = 0;
        num_frames = '0;
        out_ready  = 1;
        active     = 0;
        m_overflow = 0;
        idleInputs();
        applyStimulus();
        applyStimulus();
        checkOutput("reset_state", allOutputs(), 0);
        rst_n = 1;
        applyStimulus();

        $display("[TB] single frame, ready held high");
        runFrames(1, 0, 0, 0, 0, 1);
        $display("[TB] three frames");
        runFrames(3, 0, 0, 0, 0, 0);
        $display("[TB] FIFO overrun with ready low");
        runFrames(1, 0, 0, 0, 6, 0);
        $display("[TB] full FIFO push with simultaneous pop");
        runFrames(1, 0, 0, 0, DEPTH, 0);
        $display("[TB] num_frames zero, random traffic");
        runFrames(0, 0, 0, 0, -1, 0);
        $display("[TB] continuous dropped after third frame");
        runFrames(2, 3, 0, 0, -1, 0);
        $display("[TB] continuous with abort in frame 2");
        runFrames(1, 100, 1, 2, -1, 0);

        $display("[TB] abort together with start while idle");
        start = 1; abort = 1;
        applyStimulus();
        checkOutput("abort_beats_start", {busy, frame_start}, 0);
        idleInputs();
        applyStimulus();

        $display("[TB] reset during run, then single frame again");
        runFrames(2, 0, 2, 1, -1, 0);
        runFrames(1, 0, 0, 0, 0, 1);

        for (int k = 0; k < 3; k++) begin
            runFrames($urandom_range(1, 3), 0, 0, 0, -1, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
